// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the set-associative instruction cache.
// Field helpers work on a 64-bit zero-extended address; callers cast the result to the field width.
package icache_pkg;

  localparam int unsigned ADDR_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [ADDR_MAX-1:0] low_mask(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

  // Word offset inside a block (byte bits [1:0] are always zero for instruction fetches).
  function automatic logic [ADDR_MAX-1:0] addr_offset(input logic [ADDR_MAX-1:0] addr,
                                                      input int unsigned     block_width);
    return (addr >> 2) & low_mask(block_width);
  endfunction

  function automatic logic [ADDR_MAX-1:0] addr_index(input logic [ADDR_MAX-1:0] addr,
                                                     input int unsigned     block_width,
                                                     input int unsigned     set_width);
    return (addr >> (block_width + 2)) & low_mask(set_width);
  endfunction

  function automatic logic [ADDR_MAX-1:0] addr_tag(input logic [ADDR_MAX-1:0] addr,
                                                   input int unsigned     block_width,
                                                   input int unsigned     set_width);
    return addr >> (block_width + set_width + 2);
  endfunction

  function automatic logic [ADDR_MAX-1:0] block_base(input logic [ADDR_MAX-1:0] addr,
                                                     input int unsigned     block_width);
    return addr & ~low_mask(block_width + 2);
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and data block, with combinational lookup
// at a shared index and a single-block write port.
module icache_way
  import icache_pkg::*;
#(
  parameter int BLOCK_WIDTH = 2,
  parameter int SET_WIDTH   = 6,
  parameter int TAG_WIDTH   = 22
) (
  input  logic                              Sys_clk,
  input  logic                              Sys_rst_n,
  input  logic [SET_WIDTH-1:0]              index,
  input  logic [BLOCK_WIDTH-1:0]            offset,
  input  logic [TAG_WIDTH-1:0]              lookup_tag,
  input  logic                              clear,
  input  logic                              wr_en,
  input  logic [TAG_WIDTH-1:0]              wr_tag,
  input  logic [32*(1<<BLOCK_WIDTH)-1:0]    wr_block,
  output logic                              hit,
  output logic                              line_valid,
  output logic [31:0]                       word
);

  localparam int SETS       = 1 << SET_WIDTH;
  localparam int BLOCK_BITS = 32 * (1 << BLOCK_WIDTH);

  logic [SETS-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]  tag_mem  [SETS];
  logic [BLOCK_BITS-1:0] data_mem [SETS];

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst_n) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge Sys_clk) begin
    if (wr_en) begin
      tag_mem[index]  <= wr_tag;
      data_mem[index] <= wr_block;
    end
  end

  assign line_valid = valid_q[index];
  assign hit        = line_valid && (tag_mem[index] == lookup_tag);
  assign word       = data_mem[index][{offset, 5'd0} +: 32];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative (1- or 2-way) instruction cache between the fetcher and the memory controller.
// Optional build macro ICACHE_PERF_CNT_EN adds saturating hit/miss counters ICPERF_hit/ICPERF_miss.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int BLOCK_WIDTH = 2,
  parameter int SET_WIDTH   = 6,
  parameter int WAYS        = 2,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                            Sys_clk,
  input  logic                            Sys_rst_n,
  input  logic                            Sys_rdy,
  input  logic                            IFIC_en,
  input  logic [ADDR_WIDTH-1:0]           IFIC_addr,
  output logic                            ICIF_en,
  output logic [31:0]                     ICIF_data,
  output logic                            ICMC_en,
  output logic [ADDR_WIDTH-1:0]           ICMC_addr,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0]                     ICPERF_hit,
  output logic [31:0]                     ICPERF_miss,
`endif
  input  logic                            MCIC_en,
  input  logic [32*(1<<BLOCK_WIDTH)-1:0]  MCIC_block,
  input  logic                            RoBIC_pre_judge,
  input  logic                            RoBIC_flush
);

  localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - BLOCK_WIDTH - 2;
  localparam int SETS      = 1 << SET_WIDTH;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic                    kill_q, kill_d;
  logic                    no_alloc_q, no_alloc_d;
  logic                    icif_en_d, icmc_en_d;
  logic [31:0]             icif_data_d;
  logic [ADDR_WIDTH-1:0]   icmc_addr_d;

  logic [BLOCK_WIDTH-1:0]  fetch_off, req_off;
  logic [SET_WIDTH-1:0]    fetch_index, req_index, set_index;
  logic [TAG_WIDTH-1:0]    fetch_tag, req_tag;
  logic [ADDR_WIDTH-1:0]   fetch_base;

  logic [WAYS-1:0]         way_hit, way_valid;
  logic [31:0]             way_word [WAYS];
  logic                    hit_any, hit_way, victim;
  logic [31:0]             hit_word, refill_word;
  logic                    accept, hit_update, refill_write;

  assign fetch_off   = BLOCK_WIDTH'(addr_offset(64'(IFIC_addr), BLOCK_WIDTH));
  assign fetch_index = SET_WIDTH'(addr_index(64'(IFIC_addr), BLOCK_WIDTH, SET_WIDTH));
  assign fetch_tag   = TAG_WIDTH'(addr_tag(64'(IFIC_addr), BLOCK_WIDTH, SET_WIDTH));
  assign fetch_base  = ADDR_WIDTH'(block_base(64'(IFIC_addr), BLOCK_WIDTH));
  assign req_off     = BLOCK_WIDTH'(addr_offset(64'(req_addr_q), BLOCK_WIDTH));
  assign req_index   = SET_WIDTH'(addr_index(64'(req_addr_q), BLOCK_WIDTH, SET_WIDTH));
  assign req_tag     = TAG_WIDTH'(addr_tag(64'(req_addr_q), BLOCK_WIDTH, SET_WIDTH));

  // While a refill is outstanding the arrays are addressed by the latched miss, not the live fetch.
  assign set_index   = (state_q == MISS) ? req_index : fetch_index;
  assign refill_word = MCIC_block[{req_off, 5'd0} +: 32];
  assign accept      = IFIC_en && (state_q == IDLE) && !ICIF_en;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .BLOCK_WIDTH (BLOCK_WIDTH),
      .SET_WIDTH   (SET_WIDTH),
      .TAG_WIDTH   (TAG_WIDTH)
    ) u_way (
      .Sys_clk    (Sys_clk),
      .Sys_rst_n  (Sys_rst_n),
      .index      (set_index),
      .offset     (fetch_off),
      .lookup_tag (fetch_tag),
      .clear      (Sys_rdy && RoBIC_flush),
      .wr_en      (Sys_rst_n && Sys_rdy && refill_write && (victim == 1'(w))),
      .wr_tag     (req_tag),
      .wr_block   (MCIC_block),
      .hit        (way_hit[w]),
      .line_valid (way_valid[w]),
      .word       (way_word[w])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_any  = 1'b1;
        hit_way  = 1'(w);
        hit_word = way_word[w];
      end
    end
  end

  if (WAYS == 2) begin : g_lru
    // lru_q[s] names the least-recently-used way of set s.
    logic [SETS-1:0] lru_q;

    assign victim = !way_valid[0] ? 1'b0 :
                    !way_valid[1] ? 1'b1 : lru_q[set_index];

    always_ff @(posedge Sys_clk) begin
      if (!Sys_rst_n) begin
        lru_q <= '0;
      end else if (Sys_rdy) begin
        if (RoBIC_flush) begin
          lru_q <= '0;
        end else if (hit_update) begin
          lru_q[set_index] <= ~hit_way;
        end else if (refill_write) begin
          lru_q[set_index] <= ~victim;
        end
      end
    end
  end else begin : g_direct
    assign victim = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    kill_d       = kill_q;
    no_alloc_d   = no_alloc_q;
    icif_en_d    = 1'b0;
    icif_data_d  = ICIF_data;
    icmc_en_d    = ICMC_en;
    icmc_addr_d  = ICMC_addr;
    hit_update   = 1'b0;
    refill_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hit_any) begin
            hit_update = 1'b1;
            if (RoBIC_pre_judge && !RoBIC_flush) begin
              icif_en_d   = 1'b1;
              icif_data_d = hit_word;
            end
          end else begin
            req_addr_d  = IFIC_addr;
            icmc_en_d   = 1'b1;
            icmc_addr_d = fetch_base;
            kill_d      = !RoBIC_pre_judge || RoBIC_flush;
            no_alloc_d  = RoBIC_flush;
            state_d     = MISS;
          end
        end
      end
      MISS: begin
        if (MCIC_en) begin
          icmc_en_d    = 1'b0;
          refill_write = !(no_alloc_q || RoBIC_flush);
          kill_d       = 1'b0;
          no_alloc_d   = 1'b0;
          if (kill_q || !RoBIC_pre_judge || RoBIC_flush) begin
            state_d = IDLE;
          end else begin
            state_d     = RESP;
            icif_en_d   = 1'b1;
            icif_data_d = refill_word;
          end
        end else begin
          if (!RoBIC_pre_judge) kill_d = 1'b1;
          if (RoBIC_flush) begin
            kill_d     = 1'b1;
            no_alloc_d = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst_n) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      kill_q     <= 1'b0;
      no_alloc_q <= 1'b0;
      ICIF_en    <= 1'b0;
      ICIF_data  <= '0;
      ICMC_en    <= 1'b0;
      ICMC_addr  <= '0;
    end else if (Sys_rdy) begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
      no_alloc_q <= no_alloc_d;
      ICIF_en    <= icif_en_d;
      ICIF_data  <= icif_data_d;
      ICMC_en    <= icmc_en_d;
      ICMC_addr  <= icmc_addr_d;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic miss_entry;
  assign miss_entry = (state_q == IDLE) && (state_d == MISS);

  // Counters survive flush; only reset clears them.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst_n) begin
      ICPERF_hit  <= '0;
      ICPERF_miss <= '0;
    end else if (Sys_rdy) begin
      if (hit_update && (ICPERF_hit != '1))  ICPERF_hit  <= ICPERF_hit + 32'd1;
      if (miss_entry && (ICPERF_miss != '1)) ICPERF_miss <= ICPERF_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc at default parameters: hit/miss, LRU eviction,
// misprediction kill, flush, Sys_rdy stall and mid-miss reset.
module tb_icache_assoc;

  localparam int BW = 2;
  localparam int AW = 32;

  logic                     Sys_clk;
  logic                     Sys_rst_n;
  logic                     Sys_rdy;
  logic                     IFIC_en;
  logic [AW-1:0]            IFIC_addr;
  logic                     ICIF_en;
  logic [31:0]              ICIF_data;
  logic                     ICMC_en;
  logic [AW-1:0]            ICMC_addr;
  logic                     MCIC_en;
  logic [32*(1<<BW)-1:0]    MCIC_block;
  logic                     RoBIC_pre_judge;
  logic                     RoBIC_flush;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]              ICPERF_hit;
  logic [31:0]              ICPERF_miss;
`endif

  int vectors     = 0;
  int miscompares = 0;

  icache_assoc dut (
    .Sys_clk         (Sys_clk),
    .Sys_rst_n       (Sys_rst_n),
    .Sys_rdy         (Sys_rdy),
    .IFIC_en         (IFIC_en),
    .IFIC_addr       (IFIC_addr),
    .ICIF_en         (ICIF_en),
    .ICIF_data       (ICIF_data),
    .ICMC_en         (ICMC_en),
    .ICMC_addr       (ICMC_addr),
`ifdef ICACHE_PERF_CNT_EN
    .ICPERF_hit      (ICPERF_hit),
    .ICPERF_miss     (ICPERF_miss),
`endif
    .MCIC_en         (MCIC_en),
    .MCIC_block      (MCIC_block),
    .RoBIC_pre_judge (RoBIC_pre_judge),
    .RoBIC_flush     (RoBIC_flush)
  );

  initial Sys_clk = 1'b0;
  always #5 Sys_clk = ~Sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic fetch(input logic [AW-1:0] addr);
    IFIC_en   = 1'b1;
    IFIC_addr = addr;
    tick();
    IFIC_en   = 1'b0;
  endtask

  task automatic refill(input logic [32*(1<<BW)-1:0] blk);
    MCIC_en    = 1'b1;
    MCIC_block = blk;
    tick();
    MCIC_en    = 1'b0;
  endtask

  function automatic logic [32*(1<<BW)-1:0] mk_block(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  initial begin
    Sys_rst_n       = 1'b0;
    Sys_rdy         = 1'b1;
    IFIC_en         = 1'b0;
    IFIC_addr       = '0;
    MCIC_en         = 1'b0;
    MCIC_block      = '0;
    RoBIC_pre_judge = 1'b1;
    RoBIC_flush     = 1'b0;
    tick();
    tick();
    check("rst_icif_en",   32'(ICIF_en),   32'd0);
    check("rst_icif_data", ICIF_data,      32'd0);
    check("rst_icmc_en",   32'(ICMC_en),   32'd0);
    check("rst_icmc_addr", ICMC_addr,      32'd0);
    Sys_rst_n = 1'b1;
    tick();

    // 1: cold miss, request held, refill returns word 1
    fetch(32'h0000_1004);
    check("t1_icmc_en",   32'(ICMC_en), 32'd1);
    check("t1_icmc_addr", ICMC_addr,    32'h0000_1000);
    check("t1_no_resp",   32'(ICIF_en), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_hold_en",   32'(ICMC_en), 32'd1);
      check("t1_hold_addr", ICMC_addr,    32'h0000_1000);
    end
    refill(mk_block(32'hA000_0000));
    check("t1_resp_en",   32'(ICIF_en), 32'd1);
    check("t1_resp_data", ICIF_data,    32'hA000_0001);
    check("t1_icmc_drop", 32'(ICMC_en), 32'd0);
    tick();
    check("t1_resp_pulse", 32'(ICIF_en), 32'd0);

    // 2: hit on same block, one-cycle latency
    fetch(32'h0000_1008);
    check("t2_hit_en",   32'(ICIF_en), 32'd1);
    check("t2_hit_data", ICIF_data,    32'hA000_0002);
    check("t2_no_mc",    32'(ICMC_en), 32'd0);
    tick();
    check("t2_pulse", 32'(ICIF_en), 32'd0);

    // 3: LRU replacement in set 0
    fetch(32'h0000_2000);
    check("t3_miss2000", 32'(ICMC_en), 32'd1);
    check("t3_addr2000", ICMC_addr,    32'h0000_2000);
    refill(mk_block(32'hB000_0000));
    check("t3_data2000", ICIF_data,    32'hB000_0000);
    tick();
    fetch(32'h0000_1000);
    check("t3_touch_en",   32'(ICIF_en), 32'd1);
    check("t3_touch_data", ICIF_data,    32'hA000_0000);
    tick();
    fetch(32'h0000_3000);
    check("t3_miss3000", 32'(ICMC_en), 32'd1);
    check("t3_addr3000", ICMC_addr,    32'h0000_3000);
    refill(mk_block(32'hC000_0000));
    check("t3_data3000", ICIF_data,    32'hC000_0000);
    tick();
    fetch(32'h0000_100C);
    check("t3_keep1000_en",   32'(ICIF_en), 32'd1);
    check("t3_keep1000_data", ICIF_data,    32'hA000_0003);
    check("t3_keep1000_mc",   32'(ICMC_en), 32'd0);
    tick();
    fetch(32'h0000_2000);
    check("t3_evict2000_mc",   32'(ICMC_en), 32'd1);
    check("t3_evict2000_resp", 32'(ICIF_en), 32'd0);
    refill(mk_block(32'hB000_0000));
    check("t3_re2000_data", ICIF_data, 32'hB000_0000);
    tick();

    // 4: misprediction during MISS kills the response but keeps the fill
    fetch(32'h0000_4000);
    check("t4_miss", 32'(ICMC_en), 32'd1);
    tick();
    RoBIC_pre_judge = 1'b0;
    tick();
    RoBIC_pre_judge = 1'b1;
    check("t4_hold", 32'(ICMC_en), 32'd1);
    tick();
    refill(mk_block(32'hD000_0000));
    check("t4_killed_en", 32'(ICIF_en), 32'd0);
    check("t4_mc_drop",   32'(ICMC_en), 32'd0);
    tick();
    check("t4_killed_later", 32'(ICIF_en), 32'd0);
    fetch(32'h0000_4004);
    check("t4_hit_en",   32'(ICIF_en), 32'd1);
    check("t4_hit_data", ICIF_data,    32'hD000_0001);
    tick();
    RoBIC_pre_judge = 1'b0;
    fetch(32'h0000_4008);
    RoBIC_pre_judge = 1'b1;
    check("t4_hit_suppressed", 32'(ICIF_en), 32'd0);
    check("t4_hit_no_mc",      32'(ICMC_en), 32'd0);
    tick();

    // 5: flush invalidates; flush during MISS discards the refill
    RoBIC_flush = 1'b1;
    tick();
    RoBIC_flush = 1'b0;
    fetch(32'h0000_4000);
    check("t5_flushed_miss", 32'(ICMC_en), 32'd1);
    check("t5_flushed_resp", 32'(ICIF_en), 32'd0);
    tick();
    RoBIC_flush = 1'b1;
    tick();
    RoBIC_flush = 1'b0;
    refill(mk_block(32'hE000_0000));
    check("t5_nofill_en", 32'(ICIF_en), 32'd0);
    check("t5_nofill_mc", 32'(ICMC_en), 32'd0);
    tick();
    check("t5_nofill_later", 32'(ICIF_en), 32'd0);
    fetch(32'h0000_4000);
    check("t5_not_written", 32'(ICMC_en), 32'd1);
    refill(mk_block(32'hE000_0000));
    check("t5_refill_en",   32'(ICIF_en), 32'd1);
    check("t5_refill_data", ICIF_data,    32'hE000_0000);
    tick();
    RoBIC_flush = 1'b1;
    fetch(32'h0000_4008);
    RoBIC_flush = 1'b0;
    check("t5_flush_hit_en", 32'(ICIF_en), 32'd0);
    check("t5_flush_hit_mc", 32'(ICMC_en), 32'd0);
    fetch(32'h0000_4008);
    check("t5_after_flush_mc",   32'(ICMC_en), 32'd1);
    check("t5_after_flush_addr", ICMC_addr,    32'h0000_4000);

    // Sys_rdy low: MCIC pulse is lost, state holds
    Sys_rdy = 1'b0;
    refill(mk_block(32'hF000_0000));
    check("rdy_lost_en",  32'(ICIF_en), 32'd0);
    check("rdy_hold_mc",  32'(ICMC_en), 32'd1);
    tick();
    check("rdy_hold_mc2", 32'(ICMC_en), 32'd1);

    // 6: reset mid-MISS (with Sys_rdy low), late MCIC_en ignored
    Sys_rst_n = 1'b0;
    tick();
    check("t6_rst_mc",      32'(ICMC_en), 32'd0);
    check("t6_rst_addr",    ICMC_addr,    32'd0);
    check("t6_rst_icif",    32'(ICIF_en), 32'd0);
    Sys_rst_n = 1'b1;
    Sys_rdy   = 1'b1;
    refill(mk_block(32'hF000_0000));
    check("t6_late_mc_en",   32'(ICIF_en), 32'd0);
    check("t6_late_mc_icmc", 32'(ICMC_en), 32'd0);
    tick();
    fetch(32'h0000_4008);
    check("t6_invalid_mc",   32'(ICMC_en), 32'd1);
    check("t6_invalid_resp", 32'(ICIF_en), 32'd0);
    tick();
    refill(mk_block(32'hF000_0000));
    check("t6_refill_en",   32'(ICIF_en), 32'd1);
    check("t6_refill_data", ICIF_data,    32'hF000_0002);
    tick();
    check("t6_pulse", 32'(ICIF_en), 32'd0);
    fetch(32'h0000_400C);
    check("t6_hit_en",   32'(ICIF_en), 32'd1);
    check("t6_hit_data", ICIF_data,    32'hF000_0003);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
Parametrised set-associative successor to the direct-mapped instruction cache, sitting between the instruction fetcher (IF) and the memory controller (MC).
- Configurable block size, set count and 1- or 2-way associativity, with per-set LRU replacement.
- Holds the MC request until it is acknowledged and latches the miss address, so the refill response never depends on the live IF address.
- Supports full invalidation from the reorder buffer, and discards in-flight responses when the ROB reports a misprediction.

Parameters:
- BLOCK_WIDTH, 2, log2 of words per block; BLOCK_SIZE = 1<<BLOCK_WIDTH.
- SET_WIDTH, 6, log2 of set count.
- WAYS, 2, associativity; legal values 1 or 2.
- ADDR_WIDTH, 32, byte-address width.
- TAG_WIDTH = ADDR_WIDTH-SET_WIDTH-BLOCK_WIDTH-2, derived, not overridable.

Ports:
- Sys_clk  in  1  clock, rising edge.
- Sys_rst_n  in  1  synchronous, active-low reset.
- Sys_rdy  in  1  global enable; when low all state and outputs hold.
- IFIC_en  in  1  fetch request, single-cycle pulse.
- IFIC_addr  in  ADDR_WIDTH  fetch byte address, word-aligned.
- ICIF_en  out  1  response valid, one-cycle pulse.
- ICIF_data  out  32  instruction word.
- ICMC_en  out  1  refill request, held until MCIC_en.
- ICMC_addr  out  ADDR_WIDTH  block-aligned refill address.
- MCIC_en  in  1  refill data valid, one-cycle pulse.
- MCIC_block  in  32*BLOCK_SIZE  refill block; word j is bits [32j+31:32j].
- RoBIC_pre_judge  in  1  low = misprediction this cycle; kill outstanding fetch.
- RoBIC_flush  in  1  invalidate the whole cache (fence.i).

Behaviour:
- Reset, sampled when Sys_rst_n=0 at a clock edge regardless of Sys_rdy: all valid bits 0, LRU bits 0, state IDLE, kill 0; ICIF_en=0, ICIF_data=0, ICMC_en=0, ICMC_addr=0.
- Address split: offset=addr[BLOCK_WIDTH+1:2], index=addr[BLOCK_WIDTH+SET_WIDTH+1:BLOCK_WIDTH+2], tag=upper TAG_WIDTH bits.
- States: IDLE, MISS, RESP.
- IDLE:
  - IFIC_en is accepted only in IDLE with ICIF_en low; otherwise it is ignored.
  - Hit (any way valid with tag match): ICIF_en=1 and ICIF_data=word at the next edge, a one-cycle hit latency. The hit way becomes MRU.
  - Miss: latch the request address as req_addr. At the next edge set ICMC_en=1 and ICMC_addr = req_addr with the low BLOCK_WIDTH+2 bits cleared, then go to MISS.
- MISS:
  - ICMC_en and ICMC_addr stay stable until a cycle with MCIC_en=1.
  - On that edge: ICMC_en=0. Write the block into the victim way, set its valid bit and tag, and make it MRU.
  - Victim way: the invalid way if one exists (way 0 preferred), else the LRU way.
  - If kill=0: go to RESP with ICIF_data = word[req_addr offset]. Otherwise clear kill and go to IDLE.
- RESP: ICIF_en=1 for exactly one cycle, then go to IDLE.
- Misprediction (RoBIC_pre_judge=0):
  - In MISS: set kill. The refill still completes and is written; no response is sent.
  - In the same cycle as an accepted hit: the response is suppressed (ICIF_en stays 0).
  - In the same cycle as MCIC_en: treated as kill; no response.
- RoBIC_flush:
  - Clears all valid and LRU bits at the next edge.
  - In MISS: sets kill and no-allocate. The refill is consumed but not written, and no response is sent.
  - If it coincides with a hit, the response is suppressed.
- Simultaneous events: IFIC_en together with MCIC_en is impossible (IF waits for the response). MCIC_en outside MISS is ignored.
- WAYS=1: no LRU storage; the victim is always way 0.
- Sys_rdy=0: nothing advances, including during MISS. A pulse on MCIC_en while Sys_rdy is low is lost; MC must hold MCIC_en until Sys_rdy is high.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined: adds outputs ICPERF_hit and ICPERF_miss, 32 bits each, saturating. They reset to 0 and are not cleared by flush.
  - ICPERF_hit increments once per accepted hit.
  - ICPERF_miss increments once per MISS entry.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package icache_pkg: state encoding (IDLE=0, MISS=1, RESP=2) and address-field slicing functions parametrised by BLOCK_WIDTH and SET_WIDTH.
- Sub-module icache_way: one way's tag, valid and data arrays.
  - Inputs: index, write enable, write block.
  - Outputs: hit and the selected word.
  - Instantiated WAYS times; the top holds the FSM, LRU bits and MC/IF handshake.

Test Plan:
Defaults: BLOCK_WIDTH=2, SET_WIDTH=6, WAYS=2.
1. Cold fetch 0x1004 -> ICMC_en=1 with ICMC_addr=0x1000 and held for 5 cycles. MC returns words {A0,A1,A2,A3} -> ICIF_data=A1, ICIF_en pulses once.
2. Fetch 0x1008 after test 1 -> hit; ICIF_en=1 at the next edge with A2, ICMC_en stays 0.
3. Fill 0x1000 and 0x2000 (both index 0), re-touch 0x1000, then fetch 0x3000 -> 0x2000 way evicted; 0x1000 still hits, 0x2000 misses.
4. Miss on 0x4000 with RoBIC_pre_judge=0 two cycles later -> no ICIF_en after MCIC_en; a subsequent 0x4000 fetch hits.
5. Assert RoBIC_flush after 0x1000 is resident -> next 0x1000 fetch misses. Flush during MISS -> refill not written, no response.
6. Sys_rst_n=0 mid-MISS -> ICMC_en=0 next edge, all lines invalid; a late MCIC_en is ignored.
